// File: rtl/halt_dump_if.sv
// Bundle between the halt/dump controller and its pipeline, data memory and dump sink.
// The master modport is the controller side; the slave modport is the environment side.
interface halt_dump_if;
  logic [0:31] instr_id;
  logic        instr_valid;
  logic        stall_fetch;
  logic        dmem_rd;
  logic [0:31] dmem_addr;
  logic [0:31] dmem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [0:31] dump_addr;
  logic [0:31] dump_data;
  logic        dump_last;
  logic        done;

  modport master (
    input  instr_id, instr_valid, dmem_rdata, dump_ready,
    output stall_fetch, dmem_rd, dmem_addr, dump_valid, dump_addr, dump_data, dump_last, done
  );
  modport slave (
    output instr_id, instr_valid, dmem_rdata, dump_ready,
    input  stall_fetch, dmem_rd, dmem_addr, dump_valid, dump_addr, dump_data, dump_last, done
  );
endinterface

// File: rtl/halt_dump_ctrl.sv
// On the end-of-program trap: stall fetch, let the pipe drain, then stream the
// data-memory window [DUMP_BASE, DUMP_END) out one word at a time over valid/ready.
module halt_dump_ctrl #(
  parameter logic [0:31] TRAP_WORD    = 32'h44000300,
  parameter logic [0:31] DUMP_BASE    = 32'h2000,
  parameter logic [0:31] DUMP_END     = 32'h2100,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  halt_dump_if.master bus
);
  localparam int          CW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [0:31] LAST_ADDR = DUMP_END - 32'd4;

  typedef enum logic [2:0] {IDLE, DRAIN, READ, LATCH, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [0:31]   addr, data;
  logic          trap, at_last;

  assign trap    = bus.instr_valid && (bus.instr_id == TRAP_WORD);
  // Exact match on the last word: the address never wraps past the window.
  assign at_last = (addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trap) state_nxt = DRAIN;
      DRAIN:   if (cnt == '0) state_nxt = READ;
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (bus.dump_ready) state_nxt = at_last ? DONE : READ;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Drain counter is loaded with N-1 so DRAIN occupies exactly N cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      addr <= '0;
      data <= '0;
    end else begin
      case (state)
        IDLE:    if (trap) cnt <= CW'(DRAIN_CYCLES - 1);
        DRAIN:   if (cnt == '0) addr <= DUMP_BASE;
                 else           cnt  <= cnt - CW'(1);
        LATCH:   data <= bus.dmem_rdata;
        SEND:    if (bus.dump_ready && !at_last) addr <= addr + 32'd4;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so reset zeroes them without a clock edge.
  assign bus.stall_fetch = (state != IDLE);
  assign bus.dmem_rd     = (state == READ);
  assign bus.dmem_addr   = bus.dmem_rd ? addr : '0;
  assign bus.dump_valid  = (state == SEND);
  assign bus.dump_addr   = bus.dump_valid ? addr : '0;
  assign bus.dump_data   = bus.dump_valid ? data : '0;
  assign bus.dump_last   = bus.dump_valid && at_last;
  assign bus.done        = (state == DONE);
endmodule

// File: doc/halt_dump_ctrl.md
HALT_DUMP_CTRL -- requirements
Module: halt_dump_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- TRAP_WORD, 32'h44000300, end-of-program trap encoding.
- DUMP_BASE, 32'h2000, first byte address dumped.
- DUMP_END, 32'h2100, exclusive end byte address.
- DRAIN_CYCLES, 4, cycles allowed for in-flight instructions to retire.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- instr_id  input  [0:31]  instruction currently in decode.
- instr_valid  input  1  instr_id holds a real instruction (not a bubble or flush).
- stall_fetch  output  1  freezes PC and fetch.
- dmem_rd  output  1  data-memory read strobe.
- dmem_addr  output  [0:31]  word-aligned read address.
- dmem_rdata  input  [0:31]  read data, valid the cycle after dmem_rd.
- dump_valid  output  1  dump_addr and dump_data hold a word.
- dump_ready  input  1  consumer accepts the word.
- dump_addr  output  [0:31]  address of the dumped word.
- dump_data  output  [0:31]  big-endian word {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- dump_last  output  1  current word is the final word (DUMP_END-4).
- done  output  1  dump complete.

Function
REQ-003 The FSM SHALL have the states IDLE, DRAIN, READ, LATCH, SEND and DONE.
REQ-004 IDLE SHALL move to DRAIN at the clock edge where instr_valid=1 and instr_id==TRAP_WORD; any other instruction, or a trap with instr_valid=0, SHALL leave the FSM in IDLE.
REQ-005 stall_fetch SHALL be 1 in every state except IDLE, i.e. starting the cycle after the trap is sampled.
REQ-006 DRAIN SHALL last exactly DRAIN_CYCLES cycles (down-counter loaded on entry) and then go to READ with the address register = DUMP_BASE.
REQ-007 READ SHALL last one cycle with dmem_rd=1 and dmem_addr=address register, then go to LATCH.
REQ-008 LATCH SHALL last one cycle and capture dmem_rdata into the data register at its end, then go to SEND; dmem_rd SHALL be 0 outside READ.
REQ-009 SEND SHALL assert dump_valid=1 with dump_addr=address register and dump_data=data register.
REQ-010 In SEND, dump_valid, dump_addr, dump_data and dump_last SHALL stay stable for as long as dump_ready=0.
REQ-011 On dump_valid=1 and dump_ready=1 (transfer) in SEND: if address==DUMP_END-4, the FSM SHALL go to DONE; otherwise the address SHALL advance by 4 and the FSM SHALL go to READ.
REQ-012 The address SHALL increment modulo 2^32, and the DUMP_END comparison SHALL be an exact match, so no wrap-around occurs.
REQ-013 dump_last SHALL be 1 only in SEND while address==DUMP_END-4.
REQ-014 DONE SHALL hold done=1 and stall_fetch=1 with dump_valid=0 and dmem_rd=0 until reset.
REQ-015 Trap instructions sampled in any state other than IDLE SHALL be ignored.
REQ-016 With the defaults, the dump SHALL cover 64 words, 0x2000 through 0x20FC, each word exactly once and in ascending order.
REQ-017 Latency with trap sampled at edge T and dump_ready held at 1:
- first dmem_rd in cycle T+DRAIN_CYCLES+1;
- first dump_valid in cycle T+DRAIN_CYCLES+3;
- 3 cycles per word;
- done=1 in cycle T+DRAIN_CYCLES+193.

Reset
REQ-018 rst=0 SHALL immediately, without waiting for clk, force IDLE and clear the counter, address and data registers.
REQ-019 While rst=0, every output SHALL be 0 (stall_fetch, dmem_rd, dmem_addr, dump_valid, dump_addr, dump_data, dump_last, done).
REQ-020 Reset asserted mid-DRAIN or mid-dump SHALL abandon the dump with no further dump_valid; after release, a new trap SHALL restart the dump from DUMP_BASE.
REQ-021 Release of rst SHALL take effect at the next rising edge of clk, with no spurious output pulse.

Verification
REQ-022 Scenario: trap 0x44000300 with instr_valid=1, dump_ready=1, mem[0x2000..0x2003]=DE AD BE EF -> stall_fetch=1 at T+1, first word addr 0x2000 data 0xDEADBEEF at T+7, 64 transfers, dump_last only on 0x20FC, done at T+197.
REQ-023 Scenario: instr 0x44000301, then 0x44000300 with instr_valid=0 -> FSM stays IDLE, stall_fetch=0, no dmem_rd.
REQ-024 Scenario: dump_ready=0 for 10 cycles on word 0x2004 -> dump_valid, dump_addr=0x2004 and dump_data held constant, no dmem_rd; one transfer when ready rises, next word 0x2008.
REQ-025 Scenario: rst pulsed low mid-cycle at word 0x2040 -> all outputs 0 before the next edge; after release a second trap dumps from 0x2000, 64 words total.
REQ-026 Scenario: a second trap while in DRAIN and while in DONE -> no restart, no extra transfers, done remains 1.
